// File: rtl/div_pkg.sv
// Shared constants and types for the restoring divider.
package div_pkg;

    localparam int unsigned DIV_WIDTH = 32;

    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w) + 1;
    endfunction

    localparam int unsigned DIV_CNT_W = cnt_width(DIV_WIDTH);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } div_state_e;

endpackage

// File: rtl/rem_reg.sv
// Remainder/quotient shift register with one restoring subtract step per cycle.
// The upper half holds the partial remainder and the lower half collects the quotient bits.
module rem_reg import div_pkg::*; #(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 step,
    input  logic [WIDTH-1:0]     dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic [2*WIDTH-1:0]   rem_out
);

    logic [2*WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0]   div_q, div_d;
    logic [WIDTH:0]     trial;
    logic [WIDTH:0]     diff;

    always_comb begin
        rem_d = rem_q;
        div_d = div_q;
        // Shifted upper half including the bit that leaves the top of the register.
        trial = rem_q[2*WIDTH-1:WIDTH-1];
        diff  = trial - {1'b0, div_q};
        if (load) begin
            rem_d = {{WIDTH{1'b0}}, dividend};
            div_d = divisor;
        end else if (step) begin
            // Partial remainder stays below the divisor, so diff[WIDTH] is the borrow.
            if (!diff[WIDTH]) begin
                rem_d = {diff[WIDTH-1:0], rem_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_d = {rem_q[2*WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= '0;
            div_q <= '0;
        end else begin
            rem_q <= rem_d;
            div_q <= div_d;
        end
    end

    assign rem_out = rem_q;

endmodule

// File: rtl/comp_divider.sv
// Multi-cycle unsigned divider: control FSM and iteration counter around rem_reg.
module comp_divider import div_pkg::*; #(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend_in,
    input  logic [WIDTH-1:0] divisor_in,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] quotient_out,
    output logic [WIDTH-1:0] remainder_out
);

    localparam int unsigned CntW = cnt_width(WIDTH);

    div_state_e        state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              div_zero_q, div_zero_d;
    logic              load, step;
    logic [2*WIDTH-1:0] rem;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_zero_d = div_zero_q;
        load       = 1'b0;
        step       = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    load  = 1'b1;
                    cnt_d = '0;
                    if (divisor_in == '0) begin
                        div_zero_d = 1'b1;
                        state_d    = StDone;
                    end else begin
                        div_zero_d = 1'b0;
                        state_d    = StRun;
                    end
                end else if (state_q == StDone) begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                step  = 1'b1;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_zero_q <= div_zero_d;
        end
    end

    rem_reg #(
        .WIDTH (WIDTH)
    ) u_rem_reg (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .step     (step),
        .dividend (dividend_in),
        .divisor  (divisor_in),
        .rem_out  (rem)
    );

    // A zero divisor loads {0, dividend}; the output mux turns that into all-ones / dividend.
    assign busy          = (state_q == StRun);
    assign done          = (state_q == StDone);
    assign div_zero      = div_zero_q;
    assign quotient_out  = div_zero_q ? {WIDTH{1'b1}} : rem[WIDTH-1:0];
    assign remainder_out = div_zero_q ? rem[WIDTH-1:0] : rem[2*WIDTH-1:WIDTH];

endmodule

// File: tb/tb_comp_divider.sv
// Directed self-checking bench for comp_divider with hand-computed expected results.
module tb_comp_divider;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] dividend_in;
    logic [31:0] divisor_in;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] quotient_out;
    logic [31:0] remainder_out;

    int n_checks = 0;
    int n_fail   = 0;
    int done_seen = 0;

    comp_divider #(
        .WIDTH (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .dividend_in   (dividend_in),
        .divisor_in    (divisor_in),
        .busy          (busy),
        .done          (done),
        .div_zero      (div_zero),
        .quotient_out  (quotient_out),
        .remainder_out (remainder_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts cycles with done high, sampled mid-cycle.
    always @(negedge clk) begin
        if (done) done_seen++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents an operation for one edge; returns 1 ns after the accepting edge.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        start       = 1'b1;
        dividend_in = a;
        divisor_in  = b;
        tick();
        start = 1'b0;
    endtask

    // Edges after the current point until done is seen (bounded).
    task automatic wait_done(input int max_cyc, output int cyc);
        cyc = 0;
        while (!done && cyc < max_cyc) begin
            tick();
            cyc++;
        end
    endtask

    int cyc;
    int base;

    initial begin
        rst         = 1'b1;
        start       = 1'b1;
        dividend_in = 32'd77;
        divisor_in  = 32'd3;
        tick();
        tick();
        rst   = 1'b0;
        start = 1'b0;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_dz", {31'd0, div_zero}, 32'd0);
        check("rst_q", quotient_out, 32'd0);
        check("rst_r", remainder_out, 32'd0);
        tick();

        // 100 / 7
        start_op(32'd100, 32'd7);
        check("p1_busy", {31'd0, busy}, 32'd1);
        wait_done(60, cyc);
        check("p1_latency", cyc, 32'd32);
        check("p1_q", quotient_out, 32'd14);
        check("p1_r", remainder_out, 32'd2);
        check("p1_dz", {31'd0, div_zero}, 32'd0);
        check("p1_busy_done", {31'd0, busy}, 32'd0);
        tick();
        check("p1_pulse", {31'd0, done}, 32'd0);
        check("p1_hold_q", quotient_out, 32'd14);
        tick();

        // 0xFFFFFFFF / 1 then 5 / 10
        start_op(32'hFFFF_FFFF, 32'd1);
        wait_done(60, cyc);
        check("max_latency", cyc, 32'd32);
        check("max_q", quotient_out, 32'hFFFF_FFFF);
        check("max_r", remainder_out, 32'd0);
        tick();
        start_op(32'd5, 32'd10);
        wait_done(60, cyc);
        check("small_q", quotient_out, 32'd0);
        check("small_r", remainder_out, 32'd5);
        tick();

        // 1234 / 0: done right after the accepting edge, no RUN cycles
        start_op(32'd1234, 32'd0);
        check("dz_busy", {31'd0, busy}, 32'd0);
        check("dz_done", {31'd0, done}, 32'd1);
        check("dz_q", quotient_out, 32'hFFFF_FFFF);
        check("dz_r", remainder_out, 32'd1234);
        check("dz_flag", {31'd0, div_zero}, 32'd1);
        tick();
        check("dz_pulse", {31'd0, done}, 32'd0);
        check("dz_hold_r", remainder_out, 32'd1234);
        tick();

        // 1000 / 3 with an ignored start at RUN cycle 10
        start_op(32'd1000, 32'd3);
        repeat (10) tick();
        start       = 1'b1;
        dividend_in = 32'd50;
        divisor_in  = 32'd5;
        tick();
        start = 1'b0;
        check("ign_busy", {31'd0, busy}, 32'd1);
        wait_done(60, cyc);
        check("ign_latency", 11 + cyc, 32'd32);
        check("ign_q", quotient_out, 32'd333);
        check("ign_r", remainder_out, 32'd1);
        check("ign_dz", {31'd0, div_zero}, 32'd0);
        tick();

        // 1000 / 3 aborted by reset at RUN cycle 10
        start_op(32'd1000, 32'd3);
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst  = 1'b0;
        base = done_seen;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_q", quotient_out, 32'd0);
        check("abort_r", remainder_out, 32'd0);
        check("abort_dz", {31'd0, div_zero}, 32'd0);
        repeat (40) tick();
        check("abort_no_done", done_seen - base, 32'd0);
        start_op(32'd9, 32'd2);
        wait_done(60, cyc);
        check("post_abort_latency", cyc, 32'd32);
        check("post_abort_q", quotient_out, 32'd4);
        check("post_abort_r", remainder_out, 32'd1);
        tick();

        // Back-to-back: start held through DONE with new operands
        base        = done_seen;
        start       = 1'b1;
        dividend_in = 32'd20;
        divisor_in  = 32'd6;
        tick();
        wait_done(60, cyc);
        check("b2b_1_latency", cyc, 32'd32);
        check("b2b_1_q", quotient_out, 32'd3);
        check("b2b_1_r", remainder_out, 32'd2);
        dividend_in = 32'd21;
        divisor_in  = 32'd4;
        tick();
        start = 1'b0;
        check("b2b_2_busy", {31'd0, busy}, 32'd1);
        wait_done(60, cyc);
        check("b2b_2_latency", cyc, 32'd32);
        check("b2b_2_q", quotient_out, 32'd5);
        check("b2b_2_r", remainder_out, 32'd1);
        repeat (5) tick();
        check("b2b_pulses", done_seen - base, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
